// File: rtl/trace_port_serializer_if.sv
// trace_port_serializer_if
//   Bundles the packet-word input stream, the off-chip trace port handshake
//   and the debug status/control signals of trace_port_serializer.
//   slave  : seen by the serializer (consumes packet words, drives the port)
//   master : seen by the environment (trace debugger, port sink, debug SW)
// Signals:
//   packet_word_i / packet_word_valid_i : push-only word stream, no ready
//   stall_o                             : back-pressure to the trace debugger
//   trace_data_o / trace_valid_o        : trace port beat and its valid
//   trace_ready_i                       : trace port accepts the beat
//   fifo_level_o                        : FIFO occupancy
//   overflow_o / overflow_clr_i         : sticky drop flag and its clear
interface trace_port_serializer_if #(
  parameter int WORD_WIDTH = 32,
  parameter int PORT_WIDTH = 4,
  parameter int FIFO_DEPTH = 8
);
  logic [WORD_WIDTH-1:0]         packet_word_i;
  logic                          packet_word_valid_i;
  logic                          stall_o;
  logic [PORT_WIDTH-1:0]         trace_data_o;
  logic                          trace_valid_o;
  logic                          trace_ready_i;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level_o;
  logic                          overflow_o;
  logic                          overflow_clr_i;

  modport slave (
    input  packet_word_i, packet_word_valid_i, trace_ready_i, overflow_clr_i,
    output stall_o, trace_data_o, trace_valid_o, fifo_level_o, overflow_o
  );

  modport master (
    output packet_word_i, packet_word_valid_i, trace_ready_i, overflow_clr_i,
    input  stall_o, trace_data_o, trace_valid_o, fifo_level_o, overflow_o
  );
endinterface

// File: rtl/trace_port_serializer.sv
// trace_port_serializer
//   Buffers packet words from the trace debugger in a small FIFO, raises
//   stall_o when free space runs low, and serializes each word LSB beat first
//   onto a narrow valid/ready trace port. Words arriving at a full FIFO with
//   no simultaneous pop are dropped and flagged in the sticky overflow_o.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : trace_port_serializer_if.slave (packet input, trace port, status)
// Optional feature macro: TRACE_PORT_SYNC_EN
//   When defined, a sync word ({8'hA5} repeated) is sent ahead of the first
//   FIFO word after reset and after every drop. Sync words never occupy FIFO
//   entries and do not change fifo_level_o.
module trace_port_serializer #(
  parameter int WORD_WIDTH   = 32,
  parameter int PORT_WIDTH   = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int STALL_MARGIN = 2
) (
  input logic clk_i,
  input logic rst_ni,
  trace_port_serializer_if.slave bus
);

  localparam int BEATS = WORD_WIDTH / PORT_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W:0]        PTR_ONE   = (PTR_W + 1)'(1);
  localparam logic [LVL_W-1:0]      LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0]      DEPTH_L   = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0]      MARGIN_L  = LVL_W'(STALL_MARGIN);
  localparam logic [WORD_WIDTH-1:0] SYNC_WORD = {WORD_WIDTH/8{8'hA5}};

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                 state_q, state_d;
  logic [WORD_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W:0]         wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]       level_q;
  logic                   overflow_q;
  logic [WORD_WIDTH-1:0]  shift_q;
  logic [CNT_W-1:0]       beat_q;

  logic                   fifo_empty, fifo_full;
  logic                   handshake, last_beat;
  logic                   load_word, load_sync;
  logic                   push, pop, drop;
  logic                   trace_valid;
  logic [PORT_WIDTH-1:0]  trace_data;

  // The extra pointer MSB tells a full FIFO (MSBs differ) from an empty one.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign handshake = (state_q == SHIFT) && bus.trace_ready_i;
  assign last_beat = (beat_q == LAST_BEAT);

`ifdef TRACE_PORT_SYNC_EN
  logic sync_pending_q;

  // A pending sync word takes the place of the pop; the FIFO head waits one word.
  assign load_sync = load_word && sync_pending_q;
  assign pop       = load_word && !sync_pending_q;

  // Drop wins over the clear so a drop during a sync load re-arms the flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_pending_q <= 1'b1;
    end else if (drop) begin
      sync_pending_q <= 1'b1;
    end else if (load_sync) begin
      sync_pending_q <= 1'b0;
    end
  end
`else
  assign load_sync = 1'b0;
  assign pop       = load_word;
`endif

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push = bus.packet_word_valid_i && (!fifo_full || pop);
  assign drop = bus.packet_word_valid_i && !push;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = SHIFT;
      SHIFT:   if (handshake && last_beat && fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Valid is held in SHIFT until the beat is taken, so the port never retracts.
  always_comb begin
    trace_valid = 1'b0;
    trace_data  = '0;
    load_word   = 1'b0;
    case (state_q)
      IDLE: begin
        load_word = !fifo_empty;
      end
      SHIFT: begin
        trace_valid = 1'b1;
        trace_data  = shift_q[PORT_WIDTH-1:0];
        load_word   = handshake && last_beat && !fifo_empty;
      end
      default: begin
        trace_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.packet_word_i;
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.overflow_clr_i) begin
      overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      beat_q  <= '0;
    end else if (load_word) begin
      shift_q <= load_sync ? SYNC_WORD : mem_q[rd_ptr_q[PTR_W-1:0]];
      beat_q  <= '0;
    end else if (handshake) begin
      shift_q <= shift_q >> PORT_WIDTH;
      beat_q  <= beat_q + CNT_ONE;
    end
  end

  assign bus.trace_valid_o = trace_valid;
  assign bus.trace_data_o  = trace_data;
  assign bus.fifo_level_o  = level_q;
  assign bus.overflow_o    = overflow_q;
  assign bus.stall_o       = (DEPTH_L - level_q) <= MARGIN_L;

endmodule

// File: tb/tb_trace_port_serializer.sv
// tb_trace_port_serializer
//   Directed bench for trace_port_serializer (32-bit words, 4-bit port,
//   8-entry FIFO, stall margin 2). Inputs change and outputs are sampled on
//   the falling clock edge. Build with TRACE_PORT_SYNC_EN defined to exercise
//   the sync-word sequence instead of the default scenarios.
module tb_trace_port_serializer;

  localparam int WW = 32;
  localparam int PW = 4;
  localparam int DEPTH = 8;
  localparam int MARGIN = 2;

  logic clk;
  logic rst_n;

  trace_port_serializer_if #(.WORD_WIDTH(WW), .PORT_WIDTH(PW), .FIFO_DEPTH(DEPTH)) bus_if();

  trace_port_serializer #(
    .WORD_WIDTH(WW), .PORT_WIDTH(PW), .FIFO_DEPTH(DEPTH), .STALL_MARGIN(MARGIN)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [PW-1:0] cap_q[$];
  int            cyc_q[$];
  logic [PW-1:0] exp_q[$];
  logic [WW-1:0] push_q[$];
  int            max_level;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic void clear_capture();
    cap_q.delete();
    cyc_q.delete();
    exp_q.delete();
    push_q.delete();
    max_level = 0;
  endfunction

  function automatic void add_word(input logic [WW-1:0] w);
    for (int b = 0; b < WW / PW; b++) exp_q.push_back(w[PW*b +: PW]);
  endfunction

  function automatic logic [WW-1:0] s_word(input int k);
    return 32'h8765_4321 + 32'(k) * 32'h0011_2233;
  endfunction

  // Runs for a number of cycles starting at a falling edge: records accepted
  // beats with their cycle index, tracks peak level and pushes queued words.
  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      if (bus_if.trace_valid_o && bus_if.trace_ready_i) begin
        cap_q.push_back(bus_if.trace_data_o);
        cyc_q.push_back(c);
      end
      if (int'(bus_if.fifo_level_o) > max_level) max_level = int'(bus_if.fifo_level_o);
      if (push_q.size() > 0) begin
        bus_if.packet_word_i       = push_q.pop_front();
        bus_if.packet_word_valid_i = 1'b1;
      end else begin
        bus_if.packet_word_valid_i = 1'b0;
      end
      @(negedge clk);
    end
    bus_if.packet_word_valid_i = 1'b0;
  endtask

  task automatic compare_stream(input string tag, input int first_cycle);
    int first;
    int span;
    logic [31:0] obs;
    first = (cyc_q.size() > 0) ? cyc_q[0] : -1;
    span  = (cyc_q.size() > 0) ? (cyc_q[$] - cyc_q[0] + 1) : 0;
    checkOutput({tag, "_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
    checkOutput({tag, "_first_cycle"}, 32'(first), 32'(first_cycle));
    checkOutput({tag, "_span"}, 32'(span), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < cap_q.size()) ? 32'(cap_q[i]) : 32'hFFFF_FFFF;
      checkOutput($sformatf("%s_beat%0d", tag, i), obs, 32'(exp_q[i]));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.packet_word_i       = '0;
    bus_if.packet_word_valid_i = 1'b0;
    bus_if.trace_ready_i       = 1'b0;
    bus_if.overflow_clr_i      = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(bus_if.trace_valid_o), 32'd0);
    checkOutput("rst_data", 32'(bus_if.trace_data_o), 32'd0);
    checkOutput("rst_level", 32'(bus_if.fifo_level_o), 32'd0);
    checkOutput("rst_overflow", 32'(bus_if.overflow_o), 32'd0);
    checkOutput("rst_stall", 32'(bus_if.stall_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

`ifdef TRACE_PORT_SYNC_EN
  localparam logic [WW-1:0] SYNC = 32'hA5A5_A5A5;

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // First word after reset is preceded by one sync word.
    bus_if.trace_ready_i = 1'b1;
    clear_capture();
    push_q.push_back(32'h0000_0000);
    applyStimulus(24);
    add_word(SYNC);
    add_word(32'h0000_0000);
    compare_stream("sync_reset", 2);
    checkOutput("sync_reset_level", 32'(bus_if.fifo_level_o), 32'd0);

    // Force a drop: t1 loads directly, t2..t9 fill the FIFO, t10 is dropped.
    bus_if.trace_ready_i = 1'b0;
    clear_capture();
    for (int k = 1; k <= 10; k++) push_q.push_back(32'h1111_1111 * 32'(k));
    applyStimulus(11);
    checkOutput("sync_drop_overflow", 32'(bus_if.overflow_o), 32'd1);
    checkOutput("sync_drop_level", 32'(bus_if.fifo_level_o), 32'd8);

    // Drain: t1, then a sync word ahead of the next FIFO word, then t2..t9.
    bus_if.trace_ready_i = 1'b1;
    clear_capture();
    applyStimulus(90);
    add_word(32'h1111_1111);
    add_word(SYNC);
    for (int k = 2; k <= 9; k++) add_word(32'h1111_1111 * 32'(k));
    compare_stream("sync_drop", 0);
    checkOutput("sync_drop_idle", 32'(bus_if.trace_valid_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
`else
  localparam logic [7:0] LVL_TBL   [11] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5,
                                            8'd6, 8'd7, 8'd8, 8'd8, 8'd8};
  localparam logic       STALL_TBL [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                            1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic       OVF_TBL   [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                            1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Single word, ready held high: beats 8..1, first beat two cycles after push.
    bus_if.trace_ready_i = 1'b1;
    clear_capture();
    push_q.push_back(32'h1234_5678);
    applyStimulus(12);
    add_word(32'h1234_5678);
    compare_stream("single", 2);
    checkOutput("single_idle_valid", 32'(bus_if.trace_valid_o), 32'd0);
    checkOutput("single_idle_data", 32'(bus_if.trace_data_o), 32'd0);
    checkOutput("single_level", 32'(bus_if.fifo_level_o), 32'd0);

    // Three words on consecutive cycles: 24 beats without a bubble.
    clear_capture();
    push_q.push_back(32'hDEAD_BEEF);
    push_q.push_back(32'h0F1E_2D3C);
    push_q.push_back(32'h7654_3210);
    applyStimulus(30);
    add_word(32'hDEAD_BEEF);
    add_word(32'h0F1E_2D3C);
    add_word(32'h7654_3210);
    compare_stream("b2b", 2);
    checkOutput("b2b_peak_level", 32'(max_level), 32'd2);

    // Back-pressure: first beat must hold for ten stalled cycles.
    bus_if.trace_ready_i = 1'b0;
    clear_capture();
    push_q.push_back(32'hCAFE_BABE);
    applyStimulus(3);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("bp_valid%0d", i), 32'(bus_if.trace_valid_o), 32'd1);
      checkOutput($sformatf("bp_data%0d", i), 32'(bus_if.trace_data_o), 32'hE);
      @(negedge clk);
    end
    bus_if.trace_ready_i = 1'b1;
    clear_capture();
    applyStimulus(10);
    add_word(32'hCAFE_BABE);
    compare_stream("bp", 0);

    // Fill with ready low: s0 sits in the shifter, s1..s8 fill, s9/s10 drop.
    bus_if.trace_ready_i = 1'b0;
    for (int k = 0; k < 11; k++) begin
      bus_if.packet_word_i       = s_word(k);
      bus_if.packet_word_valid_i = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("fill_level%0d", k), 32'(bus_if.fifo_level_o), 32'(LVL_TBL[k]));
      checkOutput($sformatf("fill_stall%0d", k), 32'(bus_if.stall_o), 32'(STALL_TBL[k]));
      checkOutput($sformatf("fill_overflow%0d", k), 32'(bus_if.overflow_o), 32'(OVF_TBL[k]));
    end

    // Drop and clear in the same cycle: the set wins.
    bus_if.packet_word_i  = s_word(11);
    bus_if.overflow_clr_i = 1'b1;
    @(negedge clk);
    bus_if.packet_word_valid_i = 1'b0;
    checkOutput("ovf_set_wins", 32'(bus_if.overflow_o), 32'd1);
    @(negedge clk);
    bus_if.overflow_clr_i = 1'b0;
    checkOutput("ovf_cleared", 32'(bus_if.overflow_o), 32'd0);
    checkOutput("ovf_level_sat", 32'(bus_if.fifo_level_o), 32'd8);

    // Full FIFO: push exactly on the cycle of the last-beat handshake of s0.
    bus_if.trace_ready_i = 1'b1;
    repeat (7) @(negedge clk);
    bus_if.packet_word_i       = 32'h0BAD_F00D;
    bus_if.packet_word_valid_i = 1'b1;
    @(negedge clk);
    bus_if.packet_word_valid_i = 1'b0;
    checkOutput("fullpop_level", 32'(bus_if.fifo_level_o), 32'd8);
    checkOutput("fullpop_overflow", 32'(bus_if.overflow_o), 32'd0);
    checkOutput("fullpop_valid", 32'(bus_if.trace_valid_o), 32'd1);

    // Drain: s1..s8 then the word accepted while full.
    clear_capture();
    applyStimulus(80);
    for (int k = 1; k <= 8; k++) add_word(s_word(k));
    add_word(32'h0BAD_F00D);
    compare_stream("drain", 0);
    checkOutput("drain_level", 32'(bus_if.fifo_level_o), 32'd0);
    checkOutput("drain_stall", 32'(bus_if.stall_o), 32'd0);

    // Reset in the middle of a word empties everything.
    bus_if.trace_ready_i = 1'b0;
    clear_capture();
    push_q.push_back(32'h1357_9BDF);
    push_q.push_back(32'h2468_ACE0);
    applyStimulus(4);
    checkOutput("midrst_pre_level", 32'(bus_if.fifo_level_o), 32'd1);
    do_reset();
    bus_if.trace_ready_i = 1'b1;
    clear_capture();
    push_q.push_back(32'hA1B2_C3D4);
    applyStimulus(12);
    add_word(32'hA1B2_C3D4);
    compare_stream("postrst", 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
`endif

endmodule
